// File: rtl/wta_pkg.sv
// ---------------------------------------------------------------------------
// wta_pkg
// Shared definitions for the winner-take-all scanner.
//   state_t  : controller states (IDLE accepts, SCAN walks channels,
//              HOLD presents the result until downstream takes it)
//   idx_w()  : width of a channel index for a given channel count, never
//              below one bit so a 2-channel build still has a real index
// ---------------------------------------------------------------------------
package wta_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wta_cmp.sv
// ---------------------------------------------------------------------------
// wta_cmp
// Combinational challenger-versus-best comparator.
//   chal   [W-1:0] in  : challenger value
//   best   [W-1:0] in  : current best value
//   margin [W-1:0] in  : bonus added to the challenger (0 for a plain compare)
//   win            out : challenger + margin >= best (ties go to challenger)
// The sum is formed one bit wider than the operands so a large margin on a
// large challenger can never wrap around and lose.
// ---------------------------------------------------------------------------
module wta_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] chal,
  input  logic [W-1:0] best,
  input  logic [W-1:0] margin,
  output logic         win
);

  logic [W:0] chal_sum;

  assign chal_sum = {1'b0, chal} + {1'b0, margin};
  assign win      = (chal_sum >= {1'b0, best});

endmodule

// File: rtl/wta_scan.sv
// ---------------------------------------------------------------------------
// wta_scan
// Sequential winner-take-all over N_CH channels, one channel per cycle,
// with optional hysteresis toward the previous winner.
//   clk                      in  : clock, rising edge
//   rst                      in  : synchronous active-high reset
//   in_data   [N_CH*W-1:0]   in  : channel i at bits [i*W +: W]
//   in_valid                 in  : sample offered
//   in_ready                 out : sample accepted this cycle (IDLE only)
//   hyst_en                  in  : apply hysteresis to this sample
//   out_data  [N_CH*W-1:0]   out : winner value in its slot, others zero
//   out_winner[IW-1:0]       out : winning channel index
//   out_valid                out : result valid
//   out_ready                in  : downstream takes the result
// Timing: a handshake at edge k yields out_valid after edge k+N_CH.
// ---------------------------------------------------------------------------
module wta_scan
  import wta_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 4,
  parameter int HYST = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH*W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       hyst_en,
  output logic [N_CH*W-1:0]          out_data,
  output logic [idx_w(N_CH)-1:0]     out_winner,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int IW = idx_w(N_CH);
  // The counter must also reach N_CH, which marks "every channel compared".
  localparam int CW = idx_w(N_CH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_CH);

  state_t state, state_nxt;

  logic [N_CH*W-1:0] cap_data;
  logic              cap_hyst;
  logic [IW-1:0]     best_idx;
  logic [W-1:0]      best_val;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     prev_idx;
  logic              hist_valid;

  logic [W-1:0]      ch [N_CH];
  logic [IW-1:0]     scan_sel;
  logic [W-1:0]      scan_val;
  logic [W-1:0]      prev_val;
  logic              scan_win;
  logic              keep_prev;
  logic              hyst_apply;
  logic [IW-1:0]     final_idx;
  logic [W-1:0]      final_val;
  logic [N_CH*W-1:0] slot_data;

  // Unpack the captured sample so channels can be picked by index.
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch[i] = cap_data[i*W +: W];
  end

  // Once the counter passes the last channel the selector parks on channel 0;
  // the scan comparison result is ignored in that cycle anyway.
  assign scan_sel = (cnt < LAST_CNT) ? cnt[IW-1:0] : '0;
  assign scan_val = ch[scan_sel];
  assign prev_val = ch[prev_idx];

  wta_cmp #(.W(W)) u_scan_cmp (
    .chal   (scan_val),
    .best   (best_val),
    .margin ('0),
    .win    (scan_win)
  );

  // The previous winner challenges the scan result with the hysteresis bonus.
  wta_cmp #(.W(W)) u_hyst_cmp (
    .chal   (prev_val),
    .best   (best_val),
    .margin (W'(HYST)),
    .win    (keep_prev)
  );

  assign hyst_apply = cap_hyst && hist_valid && (best_idx != prev_idx) && keep_prev;
  assign final_idx  = hyst_apply ? prev_idx : best_idx;
  assign final_val  = hyst_apply ? prev_val : best_val;
  assign in_ready   = (state == IDLE);

  // One-hot slot placement of the winning value.
  always_comb begin
    slot_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (final_idx == IW'(i)) begin
        slot_data[i*W +: W] = final_val;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, walk all channels in SCAN, then wait
  // in HOLD until the result is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SCAN;
      SCAN: if (cnt == LAST_CNT) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, running best, and result/history registration.
  // The final SCAN cycle (cnt == N_CH) resolves hysteresis against the
  // fully settled best so the comparison never sits behind the scan mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_data   <= '0;
      cap_hyst   <= 1'b0;
      best_idx   <= '0;
      best_val   <= '0;
      cnt        <= '0;
      prev_idx   <= '0;
      hist_valid <= 1'b0;
      out_data   <= '0;
      out_winner <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_data <= in_data;
            cap_hyst <= hyst_en;
            best_idx <= '0;
            best_val <= in_data[W-1:0];
            cnt      <= CW'(1);
          end
        end
        SCAN: begin
          if (cnt != LAST_CNT) begin
            if (scan_win) begin
              best_idx <= scan_sel;
              best_val <= scan_val;
            end
            cnt <= cnt + CW'(1);
          end else begin
            out_data   <= slot_data;
            out_winner <= final_idx;
            out_valid  <= 1'b1;
            prev_idx   <= final_idx;
            hist_valid <= 1'b1;
            cnt        <= '0;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wta_scan.sv
// ---------------------------------------------------------------------------
// tb_wta_scan
// Directed table-driven bench for wta_scan (N_CH=4, W=4, HYST=2) plus
// hand-written sequences for backpressure and reset during a scan.
// ---------------------------------------------------------------------------
module tb_wta_scan;

  localparam int N_CH = 4;
  localparam int W    = 4;
  localparam int HYST = 2;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hyst_en;
  logic [15:0] out_data;
  logic [1:0]  out_winner;
  logic        out_valid;
  logic        out_ready;

  int assertions;
  int failures;
  int latency;

  typedef struct {
    logic [15:0] data;
    logic        hyst;
    logic [1:0]  exp_winner;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  wta_scan #(.N_CH(N_CH), .W(W), .HYST(HYST)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hyst_en    (hyst_en),
    .out_data   (out_data),
    .out_winner (out_winner),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait escapes its bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one sample, then count edges from the handshake until out_valid.
  task automatic applyStimulus(input logic [15:0] data, input logic hyst);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
    end
    in_data  = data;
    hyst_en  = hyst;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 50) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    hyst_en    = 1'b0;
    out_ready  = 1'b1;

    // Channels packed ch3..ch0 from MSB to LSB.
    vecs[0] = '{16'h1993, 1'b1, 2'd2, 16'h0900};
    vecs[1] = '{16'h19A3, 1'b1, 2'd2, 16'h0900};
    vecs[2] = '{16'h19C3, 1'b1, 2'd1, 16'h00C0};
    vecs[3] = '{16'h19A3, 1'b0, 2'd1, 16'h00A0};
    vecs[4] = '{16'h19C3, 1'b0, 2'd1, 16'h00C0};
    vecs[5] = '{16'h0000, 1'b0, 2'd3, 16'h0000};
    vecs[6] = '{16'hFFFF, 1'b1, 2'd3, 16'hF000};
    vecs[7] = '{16'hEFFF, 1'b1, 2'd3, 16'hE000};
    vecs[8] = '{16'h5772, 1'b0, 2'd2, 16'h0700};

    // Reset state, with a handshake offered during reset that must be ignored.
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("reset_in_ready",   32'(in_ready),   32'd1);
    checkOutput("reset_out_valid",  32'(out_valid),  32'd0);
    checkOutput("reset_out_data",   32'(out_data),   32'd0);
    checkOutput("reset_out_winner", 32'(out_winner), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);

    // Table-driven scan and hysteresis vectors.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].data, vecs[i].hyst);
      checkOutput($sformatf("vec%0d_latency", i), 32'(latency),          32'(N_CH));
      checkOutput($sformatf("vec%0d_winner", i),  32'(out_winner),       32'(vecs[i].exp_winner));
      checkOutput($sformatf("vec%0d_data", i),    32'(out_data),         32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready),        32'd0);
    end

    // Backpressure: result must hold and further offers must be ignored.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(16'h4321, 1'b0);
    checkOutput("bp_latency", 32'(latency), 32'(N_CH));
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 16'h0F00;
      hyst_en  = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput($sformatf("bp%0d_valid", c),    32'(out_valid),  32'd1);
      checkOutput($sformatf("bp%0d_winner", c),   32'(out_winner), 32'd3);
      checkOutput($sformatf("bp%0d_data", c),     32'(out_data),   32'h4000);
      checkOutput($sformatf("bp%0d_in_ready", c), 32'(in_ready),   32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset mid-scan: history (prev=3) must be forgotten, sample dropped.
    in_data  = 16'h4352;
    hyst_en  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midscan_rst_in_ready",  32'(in_ready),  32'd1);
    checkOutput("midscan_rst_out_valid", 32'(out_valid), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      checkOutput("midscan_no_output", 32'(seen), 32'd0);
    end
    // ch1=5 would lose to ch3=4+2 if stale history were still applied.
    applyStimulus(16'h4352, 1'b1);
    checkOutput("post_rst_latency", 32'(latency),    32'(N_CH));
    checkOutput("post_rst_winner",  32'(out_winner), 32'd1);
    checkOutput("post_rst_data",    32'(out_data),   32'h0050);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
